// File: rtl/bcd_calc_core_if.sv
// Button inputs and display outputs of the BCD calculator core.
interface bcd_calc_core_if #(
    parameter int unsigned DIGITS = 4
);
    logic [DIGITS-1:0]   btn_digit;
    logic [3:0]          btn_op;
    logic                btn_clr;
    logic [4*DIGITS-1:0] disp_bcd;
    logic                neg;
    logic                err;
    logic                busy;
    logic                valid;

    modport master (output btn_digit, btn_op, btn_clr,
                    input  disp_bcd, neg, err, busy, valid);
    modport slave  (input  btn_digit, btn_op, btn_clr,
                    output disp_bcd, neg, err, busy, valid);
endinterface

// File: rtl/bcd_calc_core.sv
// BCD calculator core: button debounce, digit entry, iterative add/sub/mul/div
// on two H-digit operands, and double-dabble conversion of the result.
module bcd_calc_core #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic           clk_in,
    input  logic           reset,
    bcd_calc_core_if.slave bus
);
    localparam int unsigned H  = DIGITS / 2;
    localparam int unsigned BW = $clog2(10 ** H);
    localparam int unsigned RW = 2 * BW;
    localparam int unsigned NB = DIGITS + 5;
    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned CW = $clog2(RW + 2);
    localparam int unsigned XW = 4 * DIGITS;

    typedef enum logic [2:0] {S_ENTRY, S_CONV_IN, S_COMPUTE, S_CONV_OUT, S_SHOW} state_e;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;

    logic [NB-1:0]     raw_c, ev_c;
    logic [DW-1:0]     deb_cnt_q [NB];
    logic [DW-1:0]     deb_cnt_d [NB];
    logic [DIGITS-1:0] dig_ev_c;
    logic [3:0]        op_ev_c;
    logic              clr_ev_c;
    op_e               op_sel_c;

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [XW-1:0] entry_q, entry_d, disp_q, disp_d, bcd_q, bcd_d;
    logic [XW-1:0] entry_inc_c, bcd_adj_c;
    logic [BW-1:0] a_q, a_d, b_q, b_d, rem_q, rem_d;
    logic [BW:0]   rem_t_c;
    logic [3:0]    dig_a_c, dig_b_c;
    logic [RW-1:0] acc_q, acc_d, bin_q, bin_d;
    logic          neg_r_q, neg_r_d, err_r_q, err_r_d;
    logic          neg_q, neg_d, err_q, err_d, busy_q, busy_d, valid_q, valid_d;

    assign raw_c    = {bus.btn_clr, bus.btn_op, bus.btn_digit};
    assign dig_ev_c = ev_c[DIGITS-1:0];
    assign op_ev_c  = ev_c[DIGITS+3:DIGITS];
    assign clr_ev_c = ev_c[NB-1];

    // Saturating run-length counters; one event on the sample that reaches DEB_CYCLES
    always_comb begin
        ev_c = '0;
        for (int i = 0; i < NB; i++) begin
            deb_cnt_d[i] = '0;
            if (raw_c[i]) begin
                ev_c[i]      = (deb_cnt_q[i] == DW'(DEB_CYCLES - 1));
                deb_cnt_d[i] = (deb_cnt_q[i] == DW'(DEB_CYCLES)) ? deb_cnt_q[i]
                                                                 : deb_cnt_q[i] + DW'(1);
            end
        end
    end

    // Debounce counter registers
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NB; i++) begin
            deb_cnt_q[i] <= reset ? '0 : deb_cnt_d[i];
        end
    end

    // Lowest-index op button wins
    always_comb begin
        op_sel_c = OP_DIV;
        if      (op_ev_c[0]) op_sel_c = OP_ADD;
        else if (op_ev_c[1]) op_sel_c = OP_SUB;
        else if (op_ev_c[2]) op_sel_c = OP_MUL;
    end

    // Per-digit modulo-10 increment of the entry register, no carry
    always_comb begin
        entry_inc_c = entry_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_ev_c[i]) begin
                entry_inc_c[4*i +: 4] = (entry_q[4*i +: 4] == 4'd9) ? 4'd0
                                                                    : entry_q[4*i +: 4] + 4'd1;
            end
        end
    end

    // Double-dabble add-3 adjust ahead of each shift
    always_comb begin
        bcd_adj_c = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Next-state and datapath sequencing
    always_comb begin
        state_d = state_q;  op_d    = op_q;    cnt_d   = cnt_q;
        entry_d = entry_q;  disp_d  = disp_q;  bcd_d   = bcd_q;
        a_d     = a_q;      b_d     = b_q;     rem_d   = rem_q;
        acc_d   = acc_q;    bin_d   = bin_q;
        neg_r_d = neg_r_q;  err_r_d = err_r_q;
        neg_d   = neg_q;    err_d   = err_q;
        dig_a_c = '0;       dig_b_c = '0;      rem_t_c = '0;

        case (state_q)
            S_ENTRY, S_SHOW: begin
                if (|op_ev_c) begin
                    op_d    = op_sel_c;
                    state_d = S_CONV_IN;
                    cnt_d   = '0;
                    a_d     = '0;
                    b_d     = '0;
                end else if (|dig_ev_c) begin
                    state_d = S_ENTRY;
                    entry_d = entry_inc_c;
                    disp_d  = entry_inc_c;
                    neg_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_CONV_IN: begin
                for (int i = 0; i < H; i++) begin
                    if (cnt_q == CW'(i)) begin
                        dig_a_c = entry_q[4*(DIGITS-1-i) +: 4];
                        dig_b_c = entry_q[4*(H-1-i) +: 4];
                    end
                end
                a_d   = a_q * BW'(10) + BW'(dig_a_c);
                b_d   = b_q * BW'(10) + BW'(dig_b_c);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(H - 1)) begin
                    state_d = S_COMPUTE;
                    cnt_d   = '0;
                    acc_d   = '0;
                    rem_d   = '0;
                    bin_d   = RW'(a_d);
                end
            end
            S_COMPUTE: begin
                cnt_d = cnt_q + CW'(1);
                case (op_q)
                    OP_ADD: if (cnt_q == '0) acc_d = RW'(a_q) + RW'(b_q);
                    OP_SUB: if (cnt_q == '0) acc_d = (a_q >= b_q) ? RW'(a_q - b_q) : RW'(b_q - a_q);
                    OP_MUL: begin
                        // bin_q holds the left-shifting multiplicand here
                        if (b_q[0]) acc_d = acc_q + bin_q;
                        bin_d = {bin_q[RW-2:0], 1'b0};
                        b_d   = {1'b0, b_q[BW-1:1]};
                    end
                    default: begin
                        // Restoring division: dividend shifts out of a_q, quotient shifts in
                        rem_t_c = {rem_q, a_q[BW-1]};
                        if (rem_t_c >= {1'b0, b_q}) begin
                            rem_d = BW'(rem_t_c - {1'b0, b_q});
                            a_d   = {a_q[BW-2:0], 1'b1};
                        end else begin
                            rem_d = BW'(rem_t_c);
                            a_d   = {a_q[BW-2:0], 1'b0};
                        end
                    end
                endcase
                if (cnt_q == '0) begin
                    neg_r_d = (op_q == OP_SUB) && (a_q < b_q);
                    err_r_d = (op_q == OP_DIV) && (b_q == '0);
                end
                if (cnt_q == CW'(BW - 1)) begin
                    state_d = S_CONV_OUT;
                    cnt_d   = '0;
                    bcd_d   = '0;
                    if (op_q == OP_DIV) bin_d = err_r_q ? '0 : RW'(a_d);
                    else                bin_d = acc_d;
                end
            end
            S_CONV_OUT: begin
                // RW shift cycles, then one cycle that commits the result
                if (cnt_q == CW'(RW)) begin
                    state_d = S_SHOW;
                    disp_d  = bcd_q;
                    neg_d   = neg_r_q;
                    err_d   = err_r_q;
                end else begin
                    {bcd_d, bin_d} = {bcd_adj_c, bin_q} << 1;
                    cnt_d          = cnt_q + CW'(1);
                end
            end
            default: state_d = S_ENTRY;
        endcase

        if (clr_ev_c) begin
            state_d = S_ENTRY;
            entry_d = '0;
            disp_d  = '0;
            neg_d   = 1'b0;
            err_d   = 1'b0;
        end

        busy_d  = (state_d == S_CONV_IN) || (state_d == S_COMPUTE) || (state_d == S_CONV_OUT);
        valid_d = (state_d == S_SHOW);
    end

    // State and datapath registers
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= S_ENTRY;  op_q    <= OP_ADD;  cnt_q   <= '0;
            entry_q <= '0;       disp_q  <= '0;      bcd_q   <= '0;
            a_q     <= '0;       b_q     <= '0;      rem_q   <= '0;
            acc_q   <= '0;       bin_q   <= '0;
            neg_r_q <= 1'b0;     err_r_q <= 1'b0;
            neg_q   <= 1'b0;     err_q   <= 1'b0;
            busy_q  <= 1'b0;     valid_q <= 1'b0;
        end else begin
            state_q <= state_d;  op_q    <= op_d;    cnt_q   <= cnt_d;
            entry_q <= entry_d;  disp_q  <= disp_d;  bcd_q   <= bcd_d;
            a_q     <= a_d;      b_q     <= b_d;     rem_q   <= rem_d;
            acc_q   <= acc_d;    bin_q   <= bin_d;
            neg_r_q <= neg_r_d;  err_r_q <= err_r_d;
            neg_q   <= neg_d;    err_q   <= err_d;
            busy_q  <= busy_d;   valid_q <= valid_d;
        end
    end

    assign bus.disp_bcd = disp_q;
    assign bus.neg      = neg_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;
    assign bus.valid    = valid_q;
endmodule

// File: tb/tb_bcd_calc_core.sv
// Self-checking bench for bcd_calc_core: directed scenarios plus randomized
// entry/op sequences compared against an integer-arithmetic calculator model.
module tb_bcd_calc_core;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned DEB    = 4;
    localparam int H  = DIGITS / 2;
    localparam int BW = $clog2(10 ** H);
    localparam int RW = 2 * BW;
    localparam int L  = H + BW + RW + 2;

    logic clk = 1'b0;
    logic reset;
    logic [DIGITS+4:0] raw;

    always #5 clk = ~clk;

    bcd_calc_core_if #(.DIGITS(DIGITS)) bus ();
    assign bus.btn_digit = raw[DIGITS-1:0];
    assign bus.btn_op    = raw[DIGITS+3:DIGITS];
    assign bus.btn_clr   = raw[DIGITS+4];

    bcd_calc_core #(.DIGITS(DIGITS), .DEB_CYCLES(DEB)) dut (
        .clk_in (clk),
        .reset  (reset),
        .bus    (bus)
    );

    // Calculator model: entry digits and the value currently on the display
    int                  dig [DIGITS];
    logic [4*DIGITS-1:0] shown;
    int                  n_checks = 0;
    int                  n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] entry_bcd();
        logic [4*DIGITS-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'(dig[i]);
        return r;
    endfunction

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r = '0;
        int t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int op_a();
        int v = 0;
        for (int k = 0; k < H; k++) v = v * 10 + dig[DIGITS-1-k];
        return v;
    endfunction

    function automatic int op_b();
        int v = 0;
        for (int k = 0; k < H; k++) v = v * 10 + dig[H-1-k];
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, " disp"},  64'(bus.disp_bcd), 64'(shown));
        check_val({tag, " neg"},   64'(bus.neg),   64'd0);
        check_val({tag, " err"},   64'(bus.err),   64'd0);
        check_val({tag, " busy"},  64'(bus.busy),  64'd0);
        check_val({tag, " valid"}, 64'(bus.valid), 64'd0);
    endtask

    // Press a digit button long enough to register, then release
    task automatic press_digit(input int idx, input int len);
        raw[idx] = 1'b1;
        tick(len);
        raw[idx] = 1'b0;
        tick(1);
        dig[idx] = (dig[idx] + 1) % 10;
        shown    = entry_bcd();
        check_idle_outputs("digit");
    endtask

    // Too-short pulse: must not change anything on the display
    task automatic pulse_short(input int idx, input int len);
        raw[idx] = 1'b1;
        tick(len);
        raw[idx] = 1'b0;
        tick(1);
        check_val("short pulse disp", 64'(bus.disp_bcd), 64'(shown));
    endtask

    task automatic set_operands(input int a, input int b, input int len);
        int t [DIGITS];
        int pw = 1;
        for (int k = 0; k < H; k++) begin
            t[k]     = (b / pw) % 10;
            t[H + k] = (a / pw) % 10;
            pw       = pw * 10;
        end
        for (int i = 0; i < DIGITS; i++) begin
            int n = (t[i] - dig[i] + 10) % 10;
            for (int p = 0; p < n; p++) press_digit(i, len);
        end
    endtask

    // Press op button(s); checks latency, busy span, held display and result
    task automatic do_op(input logic [3:0] mask, input int hold, input string tag);
        int a = op_a();
        int b = op_b();
        int res = 0;
        int busy_n = 0;
        int first_valid = -1;
        logic ng = 1'b0;
        logic er = 1'b0;
        if (mask[0])      res = a + b;
        else if (mask[1]) begin res = (a >= b) ? a - b : b - a; ng = (a < b); end
        else if (mask[2]) res = a * b;
        else if (b == 0)  begin res = 0; er = 1'b1; end
        else              res = a / b;

        raw[DIGITS +: 4] = mask;
        for (int j = 1; j <= L + int'(DEB) + 20; j++) begin
            @(negedge clk);
            if (j == hold) raw[DIGITS +: 4] = '0;
            if (bus.busy) busy_n++;
            if (j == int'(DEB) + 5) check_val({tag, " held disp"}, 64'(bus.disp_bcd), 64'(shown));
            if (j >= int'(DEB) && first_valid < 0 && bus.valid) first_valid = j;
            if (first_valid >= 0 && j >= hold) break;
        end
        raw[DIGITS +: 4] = '0;
        tick(1);
        shown = to_bcd(res);
        check_val({tag, " latency"}, 64'(first_valid), 64'(int'(DEB) + L - 1));
        check_val({tag, " busy cycles"}, 64'(busy_n), 64'(L - 1));
        check_val({tag, " disp"},  64'(bus.disp_bcd), 64'(shown));
        check_val({tag, " neg"},   64'(bus.neg),   64'(ng));
        check_val({tag, " err"},   64'(bus.err),   64'(er));
        check_val({tag, " valid"}, 64'(bus.valid), 64'd1);
        check_val({tag, " busy"},  64'(bus.busy),  64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        raw   = '0;
        reset = 1'b1;
        for (int i = 0; i < DIGITS; i++) dig[i] = 0;
        shown = '0;
        tick(3);
        check_idle_outputs("reset");
        reset = 1'b0;
        tick(2);
        check_idle_outputs("post reset");

        // 12 + 34, then 12 - 34, then a digit press back into entry
        set_operands(12, 34, 10);
        check_val("entry 1234", 64'(bus.disp_bcd), 64'h1234);
        do_op(4'b0001, 10, "add");
        check_val("add literal", 64'(bus.disp_bcd), 64'h0046);
        do_op(4'b0010, 10, "sub");
        check_val("sub literal", 64'(bus.disp_bcd), 64'h0022);
        check_val("sub neg literal", 64'(bus.neg), 64'd1);
        press_digit(0, 10);
        check_val("after show digit", 64'(bus.disp_bcd), 64'h1235);

        // 99 * 99, 99 / 99, 99 / 7
        set_operands(99, 99, 10);
        do_op(4'b0100, 10, "mul");
        check_val("mul literal", 64'(bus.disp_bcd), 64'h9801);
        do_op(4'b1000, 10, "div");
        check_val("div literal", 64'(bus.disp_bcd), 64'h0001);
        set_operands(99, 7, 10);
        do_op(4'b1000, 10, "div7");
        check_val("div7 literal", 64'(bus.disp_bcd), 64'h0014);

        // Divide by zero, then add on the same operands
        set_operands(99, 0, 10);
        do_op(4'b1000, 10, "div0");
        check_val("div0 err literal", 64'(bus.err), 64'd1);
        do_op(4'b0001, 10, "add after div0");
        check_val("add99 literal", 64'(bus.disp_bcd), 64'h0099);

        // Debounce and digit wrap
        pulse_short(1, 3);
        for (int p = 0; p < 9; p++) press_digit(0, 10);
        check_val("digit0 nine", 64'(bus.disp_bcd), 64'h9909);
        press_digit(0, 10);
        check_val("digit0 wrap", 64'(bus.disp_bcd), 64'h9900);
        set_operands(12, 34, 10);
        do_op(4'b0011, 10, "add+sub");
        check_val("add wins literal", 64'(bus.disp_bcd), 64'h0046);

        // Clear in the middle of a multiply
        set_operands(99, 99, 10);
        raw[DIGITS + 2] = 1'b1;
        tick(5);
        raw[DIGITS + 2] = 1'b0;
        tick(1);
        raw[DIGITS + 4] = 1'b1;
        tick(DEB - 1);
        check_val("busy before clr", 64'(bus.busy), 64'd1);
        tick(1);
        raw[DIGITS + 4] = 1'b0;
        for (int i = 0; i < DIGITS; i++) dig[i] = 0;
        shown = '0;
        check_idle_outputs("clear");
        tick(L + 10);
        check_idle_outputs("clear no stale");
        press_digit(0, 10);
        check_val("entry after clr", 64'(bus.disp_bcd), 64'h0001);

        // Reset during compute
        set_operands(45, 67, 10);
        raw[DIGITS + 2] = 1'b1;
        tick(DEB + 6);
        raw[DIGITS + 2] = 1'b0;
        check_val("busy before reset", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        tick(1);
        for (int i = 0; i < DIGITS; i++) dig[i] = 0;
        shown = '0;
        check_idle_outputs("reset mid compute");
        reset = 1'b0;
        tick(L + 10);
        check_idle_outputs("reset no stale");

        // Randomized entry/op sequences
        for (int it = 0; it < 30; it++) begin
            int np = int'($urandom_range(0, 4));
            if (it % 3 == 0)
                set_operands(int'($urandom_range(0, 99)), int'($urandom_range(0, 99)), int'(DEB) + 1);
            for (int p = 0; p < np; p++)
                press_digit(int'($urandom_range(0, DIGITS - 1)), int'($urandom_range(DEB, DEB + 5)));
            if ($urandom_range(0, 3) == 0)
                pulse_short(int'($urandom_range(0, DIGITS - 1)), int'($urandom_range(1, DEB - 1)));
            if ($urandom_range(0, 5) == 0)
                set_operands(op_a(), 0, int'(DEB));
            do_op(4'($urandom_range(1, 15)), int'($urandom_range(DEB, DEB + 6)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
